// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  // Default payload width in bits
  localparam int DATA_W_DEF = 8;

  // Destination select encoding carried on in_sel
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Occupancy of one output holding register
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux_pkg

// File: rtl/stream_demux_1to2_out_slot.sv
// One-deep output holding register (valid + data) with load and drain.
// Latency: a loaded word appears on valid_o/data_o one cycle after load_i.
// Backpressure: accept_o drops only when FULL and the consumer is stalled.
module out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              accept_o
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;

  // Slot FSM: EMPTY fills on load; FULL refills on load, empties on drain alone, else holds
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load_i) begin
            state_q <= SLOT_FULL;
            data_q  <= data_i;
          end
        end
        SLOT_FULL: begin
          if (load_i) begin
            state_q <= SLOT_FULL;
            data_q  <= data_i;
          end else if (ready_i) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: begin
          state_q <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign valid_o  = (state_q == SLOT_FULL);
  assign data_o   = data_q;
  // Room exists if empty, or if the held word leaves on this same edge
  assign accept_o = (state_q == SLOT_EMPTY) | ready_i;

endmodule : out_slot

// File: rtl/stream_demux_1to2.sv
// Routes one valid/ready input stream to port A or B by in_sel; optional counters under DEMUX_COUNT_EN.
// Latency: one cycle from input transfer to the selected output's valid.
// Backpressure: in_ready follows only the selected slot, so a stalled port never blocks the other.
module stream_demux_1to2
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]       cnt_a,
  output logic [15:0]       cnt_b
`endif
);

  logic accept_a;
  logic accept_b;
  logic in_xfer;
  logic load_a;
  logic load_b;

  // Readiness of the addressed slot only; the other slot's state is irrelevant
  always_comb begin
    in_ready = (in_sel == SEL_B) ? accept_b : accept_a;
  end

  assign in_xfer = in_valid & in_ready;
  assign load_a  = in_xfer & (in_sel == SEL_A);
  assign load_b  = in_xfer & (in_sel == SEL_B);

  out_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_a),
    .data_i   (in_data),
    .ready_i  (a_ready),
    .valid_o  (a_valid),
    .data_o   (a_data),
    .accept_o (accept_a)
  );

  out_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_b),
    .data_i   (in_data),
    .ready_i  (b_ready),
    .valid_o  (b_valid),
    .data_o   (b_data),
    .accept_o (accept_b)
  );

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Next count: bump on each output transfer, wrapping naturally at 16 bits
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (a_valid & a_ready) cnt_a_d = cnt_a_q + 16'd1;
    if (b_valid & b_ready) cnt_b_d = cnt_b_q + 16'd1;
  end

  // Delivered-word counters, cleared by reset with priority over any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule : stream_demux_1to2

// File: tb/tb_stream_demux_1to2.sv
// Randomized and directed bench for stream_demux_1to2 against a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_stream_demux_1to2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         a_valid, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_ready;
  logic [W-1:0] b_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0]  cnt_a, cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: each port is a queue of accepted-but-undelivered words, capacity one
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit           zero_a, zero_b;   // data register known to hold its reset value
  int           exp_cnt_a, exp_cnt_b;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the reference mid-cycle, advance the reference
  task automatic cyc(input logic r, input logic iv, input logic sel, input logic [W-1:0] d,
                     input logic ar, input logic br);
    bit exp_ir;
    rst = r; in_valid = iv; in_sel = sel; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    exp_ir = sel ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
    chk("in_ready", in_ready, exp_ir);
    chk("a_valid", a_valid, qa.size() > 0);
    chk("b_valid", b_valid, qb.size() > 0);
    if (qa.size() > 0) chk("a_data", a_data, qa[0]);
    else if (zero_a)   chk("a_data_rst", a_data, 0);
    if (qb.size() > 0) chk("b_data", b_data, qb[0]);
    else if (zero_b)   chk("b_data_rst", b_data, 0);
`ifdef DEMUX_COUNT_EN
    chk("cnt_a", cnt_a, exp_cnt_a);
    chk("cnt_b", cnt_b, exp_cnt_b);
`endif
    if (r) begin
      qa.delete(); qb.delete();
      zero_a = 1; zero_b = 1;
      exp_cnt_a = 0; exp_cnt_b = 0;
    end else begin
      if (qa.size() > 0 && ar) begin void'(qa.pop_front()); exp_cnt_a = (exp_cnt_a + 1) % 65536; end
      if (qb.size() > 0 && br) begin void'(qb.pop_front()); exp_cnt_b = (exp_cnt_b + 1) % 65536; end
      if (iv && exp_ir) begin
        if (sel) begin qb.push_back(d); zero_b = 0; end
        else     begin qa.push_back(d); zero_a = 0; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_cnt_a = 0; exp_cnt_b = 0; zero_a = 0; zero_b = 0;
    rst = 1; in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 8'h00, 0, 0);

    // Reset state
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single word to A appears one cycle later
    cyc(0, 1, 0, 8'h3C, 1, 0);
    chk("r30_a_valid", a_valid, 1);
    chk("r30_a_data", a_data, 8'h3C);
    chk("r30_b_valid", b_valid, 0);
    cyc(0, 0, 0, 8'h00, 1, 0);

    // Stall A: second word refused, first held, then both delivered in order
    cyc(0, 1, 0, 8'h11, 0, 0);
    cyc(0, 1, 0, 8'h22, 0, 0);
    chk("r31_in_ready", in_ready, 0);
    chk("r31_hold", a_data, 8'h11);
    cyc(0, 1, 0, 8'h22, 1, 0);
    chk("r31_second", a_data, 8'h22);
    cyc(0, 0, 0, 8'h00, 1, 0);
    chk("r31_drained", a_valid, 0);

    // A full and stalled does not block B
    cyc(0, 1, 0, 8'h77, 0, 0);
    cyc(0, 1, 1, 8'h55, 0, 0);
    chk("r32_b_data", b_data, 8'h55);
    chk("r32_b_valid", b_valid, 1);
    chk("r32_a_data", a_data, 8'h77);

    // Reset with both ports full and stalled, even with transfers offered
    cyc(1, 1, 0, 8'hCC, 1, 1);
    chk("r34_a_valid", a_valid, 0);
    chk("r34_b_valid", b_valid, 0);
    chk("r34_in_ready", in_ready, 1);
`ifdef DEMUX_COUNT_EN
    chk("r34_cnt_a", cnt_a, 0);
    chk("r34_cnt_b", cnt_b, 0);
`endif

    // Ten back-to-back words alternating A/B, both consumers always ready
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, i[0], 8'(8'hA0 + i), 1, 1);
      chk("r33_in_ready", in_ready, 1);
    end
    cyc(0, 0, 0, 8'h00, 1, 1);
    chk("r33_idle_a", a_valid, 0);
    chk("r33_idle_b", b_valid, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, 1'($urandom),
          W'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 65537 words to A
    cyc(1, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 65537; i++) cyc(0, 1, 0, W'(i), 1, 1);
    cyc(0, 0, 0, 8'h00, 1, 1);
    chk("r35_cnt_a", cnt_a, 16'd1);
    chk("r35_cnt_b", cnt_b, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_demux_1to2

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts upstream word this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-007 SHALL have port in_sel  input  1  destination: 0 = port A, 1 = port B.
REQ-008 SHALL have ports a_valid output 1, a_ready input 1, a_data output DATA_W for destination A.
REQ-009 SHALL have ports b_valid output 1, b_ready input 1, b_data output DATA_W for destination B.
REQ-010 SHALL, with DEMUX_COUNT_EN defined, add ports cnt_a output 16 and cnt_b output 16, the per-port delivered-word counts.

Function
REQ-011 SHALL treat a transfer as valid&ready high on the same rising edge, on every port.
REQ-012 SHALL hold one output register per port, each with a valid flag and a DATA_W data field.
REQ-013 SHALL drive in_ready = ~reg_valid[sel] | out_ready[sel], with sel = in_sel, combinationally.
REQ-014 SHALL load the accepted word into the in_sel register on an input transfer; it appears on a_/b_ outputs exactly 1 cycle later.
REQ-015 SHALL clear a port's valid flag on its output transfer unless a new word loads into it on the same edge, in which case valid stays 1 and data updates.
REQ-016 SHALL give each port register two states: EMPTY (valid=0) and FULL (valid=1). EMPTY->FULL on load. FULL->EMPTY on drain without load. FULL->FULL on drain+load or hold.
REQ-017 SHALL hold a_data/b_data and a_valid/b_valid stable while valid=1 and ready=0.
REQ-018 SHALL never let a stalled port block the other: with A FULL and stalled, words with in_sel=1 are still accepted.
REQ-019 SHALL ignore in_data and in_sel when in_valid=0; no register changes.
REQ-020 SHALL sustain one word per cycle to a port whose ready stays high.
REQ-021 SHALL not drop, duplicate or reorder words within a port.

Reset
REQ-022 SHALL, on clk edge with rst=1, clear a_valid and b_valid to 0 and a_data and b_data to 0; in_ready then reads 1.
REQ-023 SHALL discard words held in output registers when rst asserts mid-operation; no transfer completes on that edge.
REQ-024 SHALL give rst priority over any simultaneous input or output transfer.

Configuration
REQ-025 SHALL compile per-port counters only when macro DEMUX_COUNT_EN is defined.
REQ-026 SHALL, with DEMUX_COUNT_EN defined, increment cnt_a/cnt_b by 1 on each output transfer on that port, reset them to 0, and wrap 0xFFFF->0x0000.
REQ-027 SHALL, without DEMUX_COUNT_EN, omit the cnt ports and logic with no other behavioural change.

Structure
REQ-028 SHALL place the DATA_W default constant and the port-select encoding (SEL_A=0, SEL_B=1) in shared package demux_pkg.
REQ-029 SHALL implement each port register as one sub-module instance of out_slot (valid/data holding register with load/drain), instantiated twice.

Verification
REQ-030 SHALL cover: after rst, in_sel=0, in_data=0x3C, in_valid=1, a_ready=1 -> next cycle a_valid=1, a_data=0x3C, b_valid=0.
REQ-031 SHALL cover: a_ready=0, send 0x11 to A, then 0x22 to A -> in_ready=0 on second word, a_data holds 0x11; a_ready=1 -> 0x11 then 0x22 delivered in order.
REQ-032 SHALL cover: A FULL and stalled, send 0x55 with in_sel=1 -> accepted, b_data=0x55 next cycle, a_data unchanged.
REQ-033 SHALL cover: 10 back-to-back words alternating A/B with both ready=1 -> one word per cycle, in_ready constantly 1, each port sees its 5 in order.
REQ-034 SHALL cover: rst asserted while both ports FULL and stalled -> next cycle a_valid=b_valid=0, in_ready=1, counters 0.
REQ-035 SHALL cover, with DEMUX_COUNT_EN: 65537 words to port A -> cnt_a=1, cnt_b=0.
